esq_ctrl: RTL

- Upstream feeder for the subframe energy accumulator.
- Accepts 16-bit signed speech samples over a valid/ready handshake and squares each one into a registered 31-bit unsigned product.
- Drives the accumulator's en/new1/sel controls so it sums exactly SUBFRAME_LEN squares per subframe, then optionally folds in the half-frame energy register.
- Signals subframe completion with a one-cycle done pulse.

---
 rtl/esq_pkg.sv | 23 ++
 rtl/squ16.sv | 55 +++++
 rtl/esq_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/esq_pkg.sv
// ----------------------------------------------------------------------------
// esq_pkg
// Shared types and constants for the subframe energy feeder (esq_ctrl) and its
// registered squarer (squ16).
//   esq_state_e : controller state encoding (IDLE, SQ, MERGE, DONE)
//   SQ_W        : width of an unsigned square of a 16-bit signed sample
//   ACC_W       : width of the downstream energy accumulator
//   CNT_W       : width of the per-subframe sample counter
// ----------------------------------------------------------------------------
package esq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SQ    = 2'd1,
        MERGE = 2'd2,
        DONE  = 2'd3
    } esq_state_e;

    localparam int SQ_W  = 31;
    localparam int ACC_W = 39;
    localparam int CNT_W = 8;

endpackage

// File: rtl/squ16.sv
// ----------------------------------------------------------------------------
// squ16
// Registered square of a 16-bit signed sample into a 31-bit unsigned product,
// one cycle of latency. The result register holds when en_i is low and is
// forced to zero when clr_i is high (clr_i wins over en_i).
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   en_i   : load the square of x_i this cycle
//   clr_i  : clear the result register this cycle
//   x_i    : 16-bit two's-complement operand
//   sq_o   : registered square, unsigned
// ----------------------------------------------------------------------------
module squ16
    import esq_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic [15:0]     x_i,
    output logic [SQ_W-1:0] sq_o
);

    logic signed [SQ_W-1:0] x_ext_s;
    logic        [SQ_W-1:0] sq_d;
    logic        [SQ_W-1:0] sq_q;

    // Sign-extend to the product width first: the true square never exceeds
    // 2^30, so a 31-bit signed multiply is exact and needs no truncation.
    assign x_ext_s = {{(SQ_W-16){x_i[15]}}, x_i};

    // Next-value selection for the product register.
    always_comb begin
        if (clr_i) begin
            sq_d = {SQ_W{1'b0}};
        end else if (en_i) begin
            sq_d = $unsigned(x_ext_s * x_ext_s);
        end else begin
            sq_d = sq_q;
        end
    end

    // Product register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sq_q <= {SQ_W{1'b0}};
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/esq_ctrl.sv
// ----------------------------------------------------------------------------
// esq_ctrl
// Upstream feeder for the subframe energy accumulator. Accepts SUBFRAME_LEN
// signed samples per subframe over a valid/ready handshake, squares each one,
// and drives the accumulator's en/new1/sel controls. Optionally follows the
// last square with one cycle that folds in the half-frame energy register.
// Every output is registered.
// Optional feature macro: ESQ_SCALE_EN adds input 'scale'; when high on an
// accepted sample, the sample is arithmetic-shifted right by 2 before squaring.
// Ports:
//   clk     : clock, rising edge          reset  : async active-low reset
//   start   : begin a subframe (IDLE only) merge : add ereg after last square
//   x_in    : signed sample               x_valid: x_in is valid
//   x_ready : a sample is accepted this cycle when x_valid is high
//   mul_out : registered square to accumulator mul_in
//   en      : accumulator enable          new1   : load (not add) first square
//   sel     : 0 = add mul_out, 1 = add ereg
//   busy    : subframe in progress        done   : one-cycle completion pulse
//   scale   : (ESQ_SCALE_EN only) pre-scale the sample by 1/4
// ----------------------------------------------------------------------------
module esq_ctrl
    import esq_pkg::*;
#(
    parameter int SUBFRAME_LEN = 40,
    parameter int DW           = 16
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            merge,
    input  logic [DW-1:0]   x_in,
    input  logic            x_valid,
`ifdef ESQ_SCALE_EN
    input  logic            scale,
`endif
    output logic            x_ready,
    output logic [SQ_W-1:0] mul_out,
    output logic            en,
    output logic            new1,
    output logic            sel,
    output logic            busy,
    output logic            done
);

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(SUBFRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    esq_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             merge_q, merge_d;
    logic             x_ready_q, x_ready_d;
    logic             en_q, en_d;
    logic             new1_q, new1_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept_s;
    logic             clr_s;
    logic signed [DW-1:0] x_sig_s;
    logic signed [DW-1:0] sq_x_s;

    assign x_sig_s = $signed(x_in);

`ifdef ESQ_SCALE_EN
    assign sq_x_s = scale ? (x_sig_s >>> 2'd2) : x_sig_s;
`else
    assign sq_x_s = x_sig_s;
`endif

    // x_ready is a register, so an accept is known one cycle ahead and the
    // squarer can be enabled directly by it.
    assign accept_s = x_valid & x_ready_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        merge_d = merge_q;
        en_d    = 1'b0;
        new1_d  = 1'b0;
        sel_d   = 1'b0;
        done_d  = 1'b0;
        clr_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    merge_d = merge;
                    count_d = {CNT_W{1'b0}};
                    state_d = SQ;
                end else begin
                    state_d = IDLE;
                end
            end
            SQ: begin
                if (accept_s) begin
                    count_d = count_q + ONE_C;
                    en_d    = 1'b1;
                    new1_d  = (count_q == {CNT_W{1'b0}});
                    // Leave on the final accept so the merge/done cycle lands
                    // directly after the last square's en cycle.
                    if (count_q == LAST_C) begin
                        state_d = merge_q ? MERGE : DONE;
                    end else begin
                        state_d = SQ;
                    end
                end else begin
                    state_d = SQ;
                end
            end
            MERGE: begin
                en_d    = 1'b1;
                sel_d   = 1'b1;
                clr_s   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        x_ready_d = (state_d == SQ);
        busy_d    = (state_d != IDLE);
    end

    // State, counter, merge latch and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= {CNT_W{1'b0}};
            merge_q   <= 1'b0;
            x_ready_q <= 1'b0;
            en_q      <= 1'b0;
            new1_q    <= 1'b0;
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            merge_q   <= merge_d;
            x_ready_q <= x_ready_d;
            en_q      <= en_d;
            new1_q    <= new1_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    squ16 u_squ16 (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (accept_s),
        .clr_i  (clr_s),
        .x_i    ($unsigned(sq_x_s)),
        .sq_o   (mul_out)
    );

    assign x_ready = x_ready_q;
    assign en      = en_q;
    assign new1    = new1_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
